// File: rtl/inequality.sv
// inequality: registered unsigned threshold/window comparator on a 4-bit
// operand. One-cycle latency, with a valid pulse tracking in_valid.
module inequality #(
  parameter int unsigned HI_T   = 5,
  parameter int unsigned LO_T   = 3,
  parameter int unsigned WIN_HI = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] NUM,
  input  logic       in_valid,
  output logic [2:0] OUT,
  output logic       out_valid
);

  localparam int unsigned NUM_W  = 4;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned MAX_T  = 15;

  // Thresholds narrowed once so that every compare is a plain 4-bit unsigned compare.
  localparam logic [NUM_W-1:0] HI_V  = NUM_W'(HI_T);
  localparam logic [NUM_W-1:0] LO_V  = NUM_W'(LO_T);
  localparam logic [NUM_W-1:0] WIN_V = NUM_W'(WIN_HI);

  // Reject out-of-range or inverted thresholds during elaboration.
  if (HI_T > MAX_T || LO_T > MAX_T || WIN_HI > MAX_T) begin : g_range_err
    $error("inequality: HI_T/LO_T/WIN_HI must be within 0..15");
  end
  if (LO_T > WIN_HI) begin : g_order_err
    $error("inequality: LO_T must not exceed WIN_HI");
  end

  logic [FLAG_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              gt_c, lt_c, win_c;

  // Raw unsigned compares of the current operand.
  always_comb begin
    gt_c  = NUM > HI_V;
    lt_c  = NUM < LO_V;
    win_c = (NUM >= LO_V) && (NUM <= WIN_V);
  end

  // Next state: load new flags on a valid input, otherwise hold them.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = {gt_c, lt_c, win_c};
    end
  end

  // Flag and valid registers; reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inequality.sv
// tb_inequality: directed and randomized checks of the inequality comparator
// against an interval-based reference model.
module tb_inequality;

  localparam int unsigned HI   = 5;
  localparam int unsigned LO   = 3;
  localparam int unsigned WHI  = 9;

  logic       clk;
  logic       rst_n;
  logic [3:0] NUM;
  logic       in_valid;
  logic [2:0] OUT;
  logic       out_valid;

  int checks;
  int errors;

  logic [2:0] exp_out;
  logic       exp_ov;

  inequality #(.HI_T(HI), .LO_T(LO), .WIN_HI(WHI)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .NUM      (NUM),
    .in_valid (in_valid),
    .OUT      (OUT),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: classify the operand by which interval of 0..15 it falls into.
  function automatic logic [2:0] ref_flags(input int n);
    logic [2:0] f;
    f = 3'b000;
    if (n >= int'(HI) + 1) f[2] = 1'b1;
    if (n <= int'(LO) - 1) f[1] = 1'b1;
    if (n >= int'(LO) && n <= int'(WHI)) f[0] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input logic [3:0] n, input logic v, input string tag);
    NUM      = n;
    in_valid = v;
    @(posedge clk);
    if (v) exp_out = ref_flags(int'(n));
    exp_ov = v;
    #1;
    chk({tag, ".out"}, {1'b0, OUT}, {1'b0, exp_out});
    chk({tag, ".valid"}, {3'b000, out_valid}, {3'b000, exp_ov});
  endtask

  // Directed step that also checks a hand-written expected flag value.
  task automatic step_k(input logic [3:0] n, input logic [2:0] k, input string tag);
    step(n, 1'b1, tag);
    chk({tag, ".const"}, {1'b0, OUT}, {1'b0, k});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_out  = 3'b000;
    exp_ov   = 1'b0;
    rst_n    = 1'b0;
    NUM      = 4'd6;
    in_valid = 1'b1;

    // Reset state, and inputs ignored while reset is held.
    #2;
    chk("reset.out", {1'b0, OUT}, 4'h0);
    chk("reset.valid", {3'b000, out_valid}, 4'h0);
    @(posedge clk); #1;
    chk("reset_hold.out", {1'b0, OUT}, 4'h0);
    chk("reset_hold.valid", {3'b000, out_valid}, 4'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Idle edge after release produces no pulse.
    step(4'd0, 1'b0, "idle");

    // Directed values, including all boundaries.
    step_k(4'd6,  3'b101, "n6");
    step_k(4'd2,  3'b010, "n2");
    step_k(4'd15, 3'b100, "n15");
    step_k(4'd0,  3'b010, "n0");
    step_k(4'd5,  3'b001, "n5");
    step_k(4'd3,  3'b001, "n3");
    step_k(4'd9,  3'b101, "n9");
    step_k(4'd10, 3'b100, "n10");

    // Hold when in_valid is low.
    step_k(4'd6, 3'b101, "hold_pre");
    step(4'd0, 1'b0, "hold");
    chk("hold.const", {1'b0, OUT}, 4'b0101);

    // Asynchronous reset pulse between edges.
    step_k(4'd6, 3'b101, "arst_pre");
    #1 rst_n = 1'b0;
    #1;
    chk("arst.out", {1'b0, OUT}, 4'h0);
    chk("arst.valid", {3'b000, out_valid}, 4'h0);
    exp_out = 3'b000;
    exp_ov  = 1'b0;
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    step(4'd7, 1'b0, "arst_post");
    step(4'd7, 1'b1, "arst_first");

    // Back-to-back sweep over every operand value.
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b1, $sformatf("sweep%0d", i));
    end

    // Random operands with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(15)), 1'($urandom_range(1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inequality.md
INEQUALITY -- requirements
Module: inequality

Parameters
REQ-001 The block SHALL have parameter HI_T, default 5, meaning the threshold for the greater-than flag.
REQ-002 The block SHALL have parameter LO_T, default 3, meaning the threshold for the less-than flag and the inclusive lower bound of the window.
REQ-003 The block SHALL have parameter WIN_HI, default 9, meaning the inclusive upper bound of the window.
REQ-004 Parameters SHALL be unsigned values in the range 0..15, with LO_T <= WIN_HI; a violation SHALL be reported at elaboration with $error.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all registers are rising-edge triggered.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port NUM, input, 4 bits: an unsigned operand.
REQ-008 The block SHALL have port in_valid, input, 1 bit: NUM is sampled on a rising edge only while in_valid is high.
REQ-009 The block SHALL have port OUT, output, 3 bits: the registered comparison flags.
REQ-010 The block SHALL have port out_valid, output, 1 bit: high for one cycle when OUT holds a newly computed result.

Function
REQ-011 OUT[2] SHALL equal (NUM > HI_T), using an unsigned 4-bit compare.
REQ-012 OUT[1] SHALL equal (NUM < LO_T), using an unsigned compare.
REQ-013 OUT[0] SHALL equal (NUM >= LO_T) && (NUM <= WIN_HI), using unsigned compares with both bounds inclusive.
REQ-014 The latency from input to output SHALL be one cycle:
- NUM sampled at edge k with in_valid high;
- OUT and out_valid updated at edge k.
REQ-015 When in_valid is low at an edge, OUT SHALL hold its previous value and out_valid SHALL be 0.
REQ-016 out_valid SHALL equal the value of in_valid registered at the previous edge; back-to-back valid inputs SHALL produce back-to-back results with no bubbles.
REQ-017 The compares SHALL be purely unsigned, with no sign extension; NUM=15 is the maximum value and there SHALL be no wrap-around.
REQ-018 Boundary rules:
- NUM==HI_T SHALL give OUT[2]=0.
- NUM==LO_T SHALL give OUT[1]=0 and OUT[0]=1.
- NUM==WIN_HI SHALL give OUT[0]=1.
REQ-019 OUT[2] and OUT[1] MAY both be 0, but SHALL never both be 1 when LO_T <= HI_T+1.
REQ-020 No combinational path SHALL exist from NUM or in_valid to OUT or out_valid.

Reset
REQ-021 Assertion of rst_n low SHALL immediately, without waiting for a clock edge, force OUT=3'b000 and out_valid=0.
REQ-022 While rst_n is low, inputs SHALL be ignored.
REQ-023 After deassertion, the first rising edge with in_valid high SHALL produce a normal result.
REQ-024 Reset asserted mid-operation SHALL discard any pending result; no out_valid pulse SHALL follow the release of reset unless in_valid is high at the edge.

Verification (default parameters)
REQ-025 NUM=6, in_valid=1, one edge -> OUT=3'b101 and out_valid=1.
REQ-026 NUM=2 -> OUT=3'b010; NUM=15 -> OUT=3'b100; NUM=0 -> OUT=3'b010.
REQ-027 Boundary cases:
- NUM=5 -> OUT=3'b001;
- NUM=3 -> OUT=3'b001;
- NUM=9 -> OUT=3'b101;
- NUM=10 -> OUT=3'b100.
REQ-028 NUM=6 valid, then NUM=0 with in_valid=0 -> OUT stays 3'b101 and out_valid=0.
REQ-029 rst_n pulsed low between clock edges while OUT=3'b101 -> OUT=3'b000 and out_valid=0 before the next edge.
REQ-030 Exhaustive sweep NUM=0..15 with continuous in_valid -> each OUT matches REQ-011..REQ-013 exactly one cycle later, and out_valid stays high throughout.
